// File: rtl/case_1_div_pkg.sv
// Shared types and helpers for the case_1 sequential signed divider.
// Helpers work at the widest legal width; callers truncate to DATA_W.
package case_1_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    localparam int MAX_W = 32;
    // Iteration counter sized for the widest legal DATA_W.
    localparam int CNT_W = $clog2(MAX_W);

    function automatic logic [MAX_W-1:0] abs_mag(input logic signed [MAX_W-1:0] v);
        return v[MAX_W-1] ? MAX_W'(-v) : MAX_W'(v);
    endfunction

    function automatic logic [MAX_W-1:0] neg_trunc(input logic [MAX_W-1:0] v);
        return -v;
    endfunction

endpackage

// File: rtl/case_1_sdiv_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit and trial-subtract.
// Zero latency; no handshake.
module case_1_sdiv_step #(
    parameter int W = 4
) (
    input  logic [W:0]   prem_in,
    input  logic         dvd_msb,
    input  logic [W-1:0] divisor,
    output logic [W:0]   prem_out,
    output logic         qbit
);

    logic [W+1:0] shifted;
    logic [W+1:0] trial;

    // One extra bit on the trial keeps the sign of prem - divisor exact.
    always_comb begin
        shifted  = {prem_in, dvd_msb};
        trial    = shifted - {2'b00, divisor};
        qbit     = ~trial[W+1];
        prem_out = qbit ? trial[W:0] : shifted[W:0];
    end

endmodule

// File: rtl/case_1_sdiv_4s_4s_4_seq.sv
// Sequential signed divider (C truncation), one quotient bit per clock; done DATA_W+1 cycles after start.
// start is only taken while ready=1; requests while busy are dropped, never queued.
module case_1_sdiv_4s_4s_4_seq
    import case_1_div_pkg::*;
#(
    parameter int ID     = 1,
    parameter int DATA_W = 4
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] quo,
    output logic [DATA_W-1:0] rem,
    output logic              dbz
);

    if (DATA_W < 2 || DATA_W > MAX_W || ID < 0) begin : g_bad_cfg
        $error("case_1_sdiv_4s_4s_4_seq: illegal parameterisation");
    end

    div_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dvd_q, dvd_d;
    logic [DATA_W-1:0] dsr_q, dsr_d;
    logic [DATA_W:0]   prem_q, prem_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              dz_q, dz_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic              dbz_q, dbz_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    logic [DATA_W:0]   step_prem;
    logic              step_qbit;

    case_1_sdiv_step #(
        .W (DATA_W)
    ) u_step (
        .prem_in  (prem_q),
        .dvd_msb  (dvd_q[DATA_W-1]),
        .divisor  (dsr_q),
        .prem_out (step_prem),
        .qbit     (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        prem_d  = prem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = DATA_W'(abs_mag(MAX_W'($signed(din0))));
                    dsr_d   = DATA_W'(abs_mag(MAX_W'($signed(din1))));
                    qneg_d  = din0[DATA_W-1] ^ din1[DATA_W-1];
                    rneg_d  = din0[DATA_W-1];
                    dz_d    = (din1 == '0);
                    prem_d  = '0;
                    cnt_d   = CNT_W'(DATA_W - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                // Quotient bits shift into the vacated low end of the dividend register.
                prem_d = step_prem;
                dvd_d  = {dvd_q[DATA_W-2:0], step_qbit};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                // With a zero divisor every trial succeeds, so prem ends as |din0| and the
                // dividend sign restores din0 exactly; only the quotient needs forcing.
                quo_d   = dz_q   ? '1
                        : qneg_q ? DATA_W'(neg_trunc(MAX_W'(dvd_q))) : dvd_q;
                rem_d   = rneg_q ? DATA_W'(neg_trunc(MAX_W'(prem_q[DATA_W-1:0])))
                                 : prem_q[DATA_W-1:0];
                dbz_d   = dz_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            prem_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            prem_q  <= prem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign quo   = quo_q;
    assign rem   = rem_q;
    assign dbz   = dbz_q;

endmodule
